// File: rtl/definitions_pkg.sv
`default_nettype none
// ============================================================================
// Module      : definitions_pkg
// Description : Shared rv32i types, text-segment bounds and the IF/ID entry.
// Revision    : 1.0 - initial release
// ============================================================================
package definitions_pkg;

    typedef logic [31:0] word_ut;

    localparam word_ut TEXT_ORG  = 32'h0000_0000;
    localparam word_ut TEXT_END  = 32'h0000_1000;
    localparam word_ut NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic   valid;
        word_ut pc;
        word_ut pc4;
        word_ut instr;
    } if_id_t;

    // Takes a 33-bit address so a PC+4 carry-out is rejected as out of range.
    function automatic logic in_text(input logic [32:0] addr);
        logic [33:0] w_from_org;
        w_from_org = {1'b0, addr} - {2'b00, TEXT_ORG};
        return (addr[1:0] == 2'b00) && !w_from_org[33] &&
               (addr <= {1'b0, TEXT_END - 32'd4});
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_if
// Description : Control, instruction-RAM and IF/ID signals of the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_stage_if;
    import definitions_pkg::*;

    logic   stall_i;
    logic   flush_i;
    logic   redirect_i;
    word_ut redirect_pc_i;
    word_ut instr_a_o;
    word_ut instr_i;
    logic   if_valid_o;
    word_ut if_pc_o;
    word_ut if_pc4_o;
    word_ut if_instr_o;
    logic   fault_o;
    word_ut fetch_count_o;

    modport master (
        input  stall_i, flush_i, redirect_i, redirect_pc_i, instr_i,
        output instr_a_o, if_valid_o, if_pc_o, if_pc4_o, if_instr_o,
               fault_o, fetch_count_o
    );

    modport slave (
        output stall_i, flush_i, redirect_i, redirect_pc_i, instr_i,
        input  instr_a_o, if_valid_o, if_pc_o, if_pc4_o, if_instr_o,
               fault_o, fetch_count_o
    );

endinterface
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_reg
// Description : IF/ID pipeline register with hold, bubble insert, async reset.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg
    import definitions_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   rst,
    input  wire logic   i_hold,
    input  wire logic   i_bubble,
    input  wire if_id_t i_entry,
    output if_id_t      o_entry
);

    if_id_t r_entry;

    // A bubble keeps pc/pc4 so the decoder's link value stays stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_entry.valid <= 1'b0;
            r_entry.pc    <= '0;
            r_entry.pc4   <= '0;
            r_entry.instr <= NOP_INSTR;
        end else if (!i_hold) begin
            if (i_bubble) begin
                r_entry.valid <= 1'b0;
                r_entry.instr <= NOP_INSTR;
            end else begin
                r_entry <= i_entry;
            end
        end
    end

    assign o_entry = r_entry;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : rv32i fetch: PC, next-PC selection, text range check, counter.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import definitions_pkg::*;
#(
    parameter word_ut RESET_PC = TEXT_ORG
) (
    input  wire logic    clk_i,
    input  wire logic    rst_i,
    fetch_stage_if.master bus
);

    word_ut      r_pc;
    logic        r_fault;
    word_ut      r_count;

    logic [32:0] w_pc_plus4;
    word_ut      w_pc_next;
    logic        w_fault_next;
    word_ut      w_count_next;
    logic        w_hold;
    logic        w_bubble;
    if_id_t      w_entry;
    if_id_t      w_if_id;

    // Priority: halted > redirect > stall > advance (normal or flush).
    always_comb begin
        w_pc_plus4    = {1'b0, r_pc} + 33'd4;
        w_pc_next     = r_pc;
        w_fault_next  = r_fault;
        w_count_next  = r_count;
        w_hold        = 1'b1;
        w_bubble      = 1'b0;
        w_entry.valid = 1'b1;
        w_entry.pc    = r_pc;
        w_entry.pc4   = w_pc_plus4[31:0];
        w_entry.instr = bus.instr_i;
        if (!r_fault) begin
            if (bus.redirect_i) begin
                w_hold   = 1'b0;
                w_bubble = 1'b1;
                if (in_text({1'b0, bus.redirect_pc_i})) begin
                    w_pc_next = bus.redirect_pc_i;
                end else begin
                    w_fault_next = 1'b1;
                end
            end else if (!bus.stall_i) begin
                w_hold = 1'b0;
                if (in_text(w_pc_plus4)) begin
                    w_pc_next = w_pc_plus4[31:0];
                    w_bubble  = bus.flush_i;
                    if (!bus.flush_i) begin
                        w_count_next = r_count + 32'd1;
                    end
                end else begin
                    w_bubble     = 1'b1;
                    w_fault_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pc    <= RESET_PC;
            r_fault <= 1'b0;
            r_count <= '0;
        end else begin
            r_pc    <= w_pc_next;
            r_fault <= w_fault_next;
            r_count <= w_count_next;
        end
    end

    if_id_reg u_if_id_reg (
        .clk      (clk_i),
        .rst      (rst_i),
        .i_hold   (w_hold),
        .i_bubble (w_bubble),
        .i_entry  (w_entry),
        .o_entry  (w_if_id)
    );

    assign bus.instr_a_o     = r_pc;
    assign bus.fault_o       = r_fault;
    assign bus.fetch_count_o = r_count;
    assign bus.if_valid_o    = w_if_id.valid;
    assign bus.if_pc_o       = w_if_id.pc;
    assign bus.if_pc4_o      = w_if_id.pc4;
    assign bus.if_instr_o    = w_if_id.instr;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed self-checking bench for fetch_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;
    import definitions_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    fetch_stage_if bus ();

    fetch_stage #(.RESET_PC(32'h0)) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    function automatic word_ut ram_word(input word_ut a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    assign bus.instr_i = ram_word(bus.instr_a_o);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input word_ut obs, input word_ut exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic st, input logic fl, input logic rd, input word_ut tgt);
        bus.stall_i       = st;
        bus.flush_i       = fl;
        bus.redirect_i    = rd;
        bus.redirect_pc_i = tgt;
    endtask

    task automatic check_reset_state(input string tag);
        check_value({tag, "_addr"},  bus.instr_a_o, 32'h0);
        check_value({tag, "_valid"}, {31'b0, bus.if_valid_o}, 32'h0);
        check_value({tag, "_instr"}, bus.if_instr_o, NOP_INSTR);
        check_value({tag, "_pc"},    bus.if_pc_o, 32'h0);
        check_value({tag, "_pc4"},   bus.if_pc4_o, 32'h0);
        check_value({tag, "_fault"}, {31'b0, bus.fault_o}, 32'h0);
        check_value({tag, "_count"}, bus.fetch_count_o, 32'h0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("rst");
        rst = 1'b0;

        // Free-running fetch to PC=0x8
        for (int i = 1; i <= 2; i++) begin
            tick();
            check_value("run_addr",  bus.instr_a_o, 32'(4 * i));
            check_value("run_pc",    bus.if_pc_o, 32'(4 * (i - 1)));
            check_value("run_pc4",   bus.if_pc4_o, 32'(4 * i));
            check_value("run_instr", bus.if_instr_o, ram_word(32'(4 * (i - 1))));
            check_value("run_count", bus.fetch_count_o, 32'(i));
        end

        // Stall for 3 cycles at PC=0x8
        set_in(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_value("stall_addr",  bus.instr_a_o, 32'h8);
            check_value("stall_pc",    bus.if_pc_o, 32'h4);
            check_value("stall_instr", bus.if_instr_o, ram_word(32'h4));
            check_value("stall_count", bus.fetch_count_o, 32'd2);
        end
        // Stall with flush still holds
        set_in(1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        check_value("stallfl_valid", {31'b0, bus.if_valid_o}, 32'h1);
        check_value("stallfl_addr",  bus.instr_a_o, 32'h8);
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check_value("unstall_pc",   bus.if_pc_o, 32'h8);
        check_value("unstall_addr", bus.instr_a_o, 32'hC);
        tick();
        check_value("run4_pc",    bus.if_pc_o, 32'hC);
        check_value("run4_count", bus.fetch_count_o, 32'd4);
        check_value("run4_addr",  bus.instr_a_o, 32'h10);

        // Redirect to 0x100 at PC=0x10
        set_in(1'b0, 1'b0, 1'b1, 32'h100);
        tick();
        check_value("redir_valid", {31'b0, bus.if_valid_o}, 32'h0);
        check_value("redir_instr", bus.if_instr_o, NOP_INSTR);
        check_value("redir_addr",  bus.instr_a_o, 32'h100);
        check_value("redir_count", bus.fetch_count_o, 32'd4);
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check_value("redir_tgt_pc",    bus.if_pc_o, 32'h100);
        check_value("redir_tgt_instr", bus.if_instr_o, ram_word(32'h100));
        check_value("redir_tgt_valid", {31'b0, bus.if_valid_o}, 32'h1);

        // Redirect combined with stall and flush
        set_in(1'b1, 1'b1, 1'b1, 32'h200);
        tick();
        check_value("redst_valid", {31'b0, bus.if_valid_o}, 32'h0);
        check_value("redst_addr",  bus.instr_a_o, 32'h200);
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check_value("redst_tgt_pc", bus.if_pc_o, 32'h200);
        check_value("redst_count",  bus.fetch_count_o, 32'd6);

        // Flush at PC=0x20
        set_in(1'b0, 1'b0, 1'b1, 32'h20);
        tick();
        set_in(1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        check_value("flush_valid", {31'b0, bus.if_valid_o}, 32'h0);
        check_value("flush_instr", bus.if_instr_o, NOP_INSTR);
        check_value("flush_addr",  bus.instr_a_o, 32'h24);
        check_value("flush_count", bus.fetch_count_o, 32'd6);
        check_value("flush_pc",    bus.if_pc_o, 32'h200);
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check_value("postfl_pc",    bus.if_pc_o, 32'h24);
        check_value("postfl_pc4",   bus.if_pc4_o, 32'h28);
        check_value("postfl_count", bus.fetch_count_o, 32'd7);

        // Misaligned redirect faults and halts
        set_in(1'b0, 1'b0, 1'b1, 32'h102);
        tick();
        check_value("mis_fault", {31'b0, bus.fault_o}, 32'h1);
        check_value("mis_addr",  bus.instr_a_o, 32'h28);
        check_value("mis_valid", {31'b0, bus.if_valid_o}, 32'h0);
        set_in(1'b0, 1'b0, 1'b1, 32'h40);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check_value("halt_addr",  bus.instr_a_o, 32'h28);
        check_value("halt_count", bus.fetch_count_o, 32'd7);
        check_value("halt_fault", {31'b0, bus.fault_o}, 32'h1);
        check_value("halt_valid", {31'b0, bus.if_valid_o}, 32'h0);
        pulse_reset();
        #1;
        check_reset_state("clr1");

        // Redirect to TEXT_END faults
        set_in(1'b0, 1'b0, 1'b1, 32'h1000);
        tick();
        check_value("end_fault", {31'b0, bus.fault_o}, 32'h1);
        check_value("end_addr",  bus.instr_a_o, 32'h0);
        pulse_reset();
        #1;
        check_reset_state("clr2");

        // Sequential run off the end of the text segment
        set_in(1'b0, 1'b0, 1'b1, 32'hFF8);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check_value("edge_addr",  bus.instr_a_o, 32'hFFC);
        check_value("edge_fault", {31'b0, bus.fault_o}, 32'h0);
        tick();
        check_value("seq_fault", {31'b0, bus.fault_o}, 32'h1);
        check_value("seq_addr",  bus.instr_a_o, 32'hFFC);
        check_value("seq_valid", {31'b0, bus.if_valid_o}, 32'h0);
        check_value("seq_count", bus.fetch_count_o, 32'd1);
        pulse_reset();

        // Asynchronous reset between edges mid-run
        set_in(1'b0, 1'b0, 1'b1, 32'h40);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (3) tick();
        check_value("prea_count", bus.fetch_count_o, 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("async");
        #1;
        rst = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
